// File: rtl/stab_seq_pkg.sv
// Shared gate-type codes and FSM state encodings for the stabilizer-gate
// sequencing controller.
package stab_seq_pkg;

    localparam logic [2:0] GT_H     = 3'd0;
    localparam logic [2:0] GT_S     = 3'd1;
    localparam logic [2:0] GT_CNOT  = 3'd2;
    localparam logic [2:0] GT_PAULI = 3'd3;

    typedef enum logic [2:0] {
        A_IDLE    = 3'd0,
        A_COLLECT = 3'd1,
        A_AMP2    = 3'd2,
        A_SCAN    = 3'd3,
        A_DRAIN   = 3'd4,
        A_HOLD    = 3'd5
    } alpha_state_t;

    typedef enum logic [2:0] {
        B_IDLE    = 3'd0,
        B_COLLECT = 3'd1,
        B_WAIT    = 3'd2,
        B_REDUCE  = 3'd3,
        B_SYNC    = 3'd4,
        B_REORDER = 3'd5,
        B_SHIFT   = 3'd6
    } beta_state_t;

    // Unknown gate codes behave as Pauli/identity.
    function automatic logic [2:0] norm_gate(input logic [2:0] gt);
        return (gt > GT_PAULI) ? GT_PAULI : gt;
    endfunction

endpackage

// File: rtl/stab_addr_delay.sv
// Enable + address shift register of depth LAT; `pending` reports any
// enable still in flight.
module stab_addr_delay #(
    parameter int AW  = 4,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_in,
    input  logic [AW-1:0] addr_in,
    output logic          en_out,
    output logic [AW-1:0] addr_out,
    output logic          pending
);

    logic [LAT-1:0] en_r;
    logic [AW-1:0]  addr_r [LAT];

    // Enable and address advance together so they never separate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r <= '0;
            for (int i = 0; i < LAT; i++) addr_r[i] <= '0;
        end else begin
            en_r[0]   <= en_in;
            addr_r[0] <= addr_in;
            for (int i = 1; i < LAT; i++) begin
                en_r[i]   <= en_r[i-1];
                addr_r[i] <= addr_r[i-1];
            end
        end
    end

    assign en_out   = en_r[LAT-1];
    assign addr_out = addr_r[LAT-1];
    assign pending  = |en_r;

endmodule

// File: rtl/stabilizer_seq_ctrl.sv
// Stabilizer-gate sequencer: alpha stage (amplitude2, basis scan, delayed
// amplitude read/write) and beta stage (literal collect, reduce, shift-out).
module stabilizer_seq_ctrl
    import stab_seq_pkg::*;
#(
    parameter int NUM_QUBIT = 4,
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [2:0]           gate_type,
    input  logic                 next_nonstab,
    input  logic [NUM_QUBIT:0]   valid_vec_cnt,
    input  logic                 ram_busy,
    output logic                 amp2_start,
    input  logic                 amp2_done,
    output logic                 rd_ram_en,
    output logic [NUM_QUBIT-1:0] rd_ram_addr,
    output logic                 rd_amp_en,
    output logic [NUM_QUBIT-1:0] rd_amp_addr,
    output logic                 wr_amp_en,
    output logic [NUM_QUBIT-1:0] wr_amp_addr,
    output logic                 rot_basis,
    output logic                 rot_basis2,
    output logic                 rot_q2,
    output logic                 mask_op,
    output logic                 alpha_done,
    input  logic                 canon_valid,
    input  logic                 lit_bl,
    output logic                 valid_p,
    output logic                 rot_left_beta,
    output logic                 rot_down_beta,
    output logic                 ld_prodq,
    output logic                 rot_left_qflag,
    output logic                 det_amp,
    output logic                 valid_out,
    output logic                 valid_p_nonstab
);

    localparam int CW = $clog2(NUM_QUBIT + 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        CNT_N    = CW'(NUM_QUBIT);
    localparam logic [CW-1:0]        CNT_LAST = CW'(NUM_QUBIT - 1);
    localparam logic [NUM_QUBIT-1:0] IDX_ONE  = NUM_QUBIT'(1);
    localparam logic [NUM_QUBIT-1:0] IDX_LAST = {NUM_QUBIT{1'b1}};

    alpha_state_t a_state_r, a_state_s;
    beta_state_t  b_state_r, b_state_s;
    logic [CW-1:0]        a_cnt_r, a_cnt_s, b_cnt_r, b_cnt_s;
    logic [CW-1:0]        lf_r, lf_s, dn_r, dn_s;
    logic [NUM_QUBIT-1:0] idx_r, idx_s;
    logic [2:0]           gate_r;
    logic gate_ld_s, amp2_set_s, valid_p_set_s, nonstab_set_s;
    logic rotate_s, rot_basis_r, shift_first_s;
    logic rd_pending_s, wr_pending_s;
    logic amp2_start_r, valid_p_r, valid_p_nonstab_r;

    assign rotate_s      = (a_state_r == A_SCAN) && !ram_busy;
    assign rd_ram_en     = rotate_s && ({1'b0, idx_r} < valid_vec_cnt);
    assign rd_ram_addr   = idx_r;
    assign rot_q2        = rd_ram_en;
    assign rot_basis     = rot_basis_r;
    assign rot_basis2    = rotate_s | rot_basis_r;
    assign mask_op       = (a_state_r == A_SCAN) || (a_state_r == A_DRAIN) || (a_state_r == A_HOLD);
    assign alpha_done    = (a_state_r == A_HOLD);
    assign shift_first_s = (b_state_r == B_SHIFT) && (b_cnt_r == '0);
    assign amp2_start      = amp2_start_r;
    assign valid_p         = valid_p_r;
    assign valid_p_nonstab = valid_p_nonstab_r;

    stab_addr_delay #(.AW(NUM_QUBIT), .LAT(RD_LAT)) u_rd_delay (
        .clk(clk), .rst_n(rst_n), .en_in(rd_ram_en), .addr_in(rd_ram_addr),
        .en_out(rd_amp_en), .addr_out(rd_amp_addr), .pending(rd_pending_s)
    );

    stab_addr_delay #(.AW(NUM_QUBIT), .LAT(WR_LAT)) u_wr_delay (
        .clk(clk), .rst_n(rst_n), .en_in(rd_ram_en), .addr_in(rd_ram_addr),
        .en_out(wr_amp_en), .addr_out(wr_amp_addr), .pending(wr_pending_s)
    );

    // Alpha next-state: collect beats, scan the basis, drain outstanding writes.
    always_comb begin
        a_state_s  = a_state_r;
        a_cnt_s    = a_cnt_r;
        idx_s      = idx_r;
        gate_ld_s  = 1'b0;
        amp2_set_s = 1'b0;
        case (a_state_r)
            A_IDLE: begin
                if (valid_in) begin
                    a_state_s = A_COLLECT;
                    a_cnt_s   = CNT_ONE;
                    gate_ld_s = 1'b1;
                end else begin
                    a_state_s = A_IDLE;
                end
            end
            A_COLLECT: begin
                if (valid_in && (a_cnt_r != CNT_N)) begin
                    a_cnt_s   = a_cnt_r + CNT_ONE;
                    gate_ld_s = 1'b1;
                end else begin
                    a_cnt_s = a_cnt_r;
                end
                if ((a_cnt_r == CNT_N) && !ram_busy) begin
                    a_cnt_s = '0;
                    idx_s   = '0;
                    case (gate_r)
                        GT_H: begin
                            a_state_s  = A_AMP2;
                            amp2_set_s = 1'b1;
                        end
                        GT_PAULI: a_state_s = A_DRAIN;
                        default:  a_state_s = A_SCAN;
                    endcase
                end else begin
                    a_state_s = A_COLLECT;
                end
            end
            A_AMP2: begin
                if (amp2_done) begin
                    a_state_s = A_SCAN;
                    idx_s     = '0;
                end else begin
                    a_state_s = A_AMP2;
                end
            end
            A_SCAN: begin
                if (!ram_busy) begin
                    if (idx_r == IDX_LAST) a_state_s = A_DRAIN;
                    else                   idx_s     = idx_r + IDX_ONE;
                end else begin
                    idx_s = idx_r;
                end
            end
            A_DRAIN: begin
                if (!(rd_pending_s || wr_pending_s)) a_state_s = A_HOLD;
                else                                 a_state_s = A_DRAIN;
            end
            A_HOLD: begin
                // A new gate overlapping the first shift-out cycle is taken here.
                if (shift_first_s) begin
                    if (valid_in) begin
                        a_state_s = A_COLLECT;
                        a_cnt_s   = CNT_ONE;
                        gate_ld_s = 1'b1;
                    end else begin
                        a_state_s = A_IDLE;
                    end
                end else begin
                    a_state_s = A_HOLD;
                end
            end
            default: a_state_s = A_IDLE;
        endcase
    end

    // Beta next-state and datapath strobes.
    always_comb begin
        b_state_s      = b_state_r;
        b_cnt_s        = b_cnt_r;
        lf_s           = lf_r;
        dn_s           = dn_r;
        valid_p_set_s  = 1'b0;
        nonstab_set_s  = 1'b0;
        rot_left_beta  = 1'b0;
        rot_down_beta  = 1'b0;
        ld_prodq       = 1'b0;
        rot_left_qflag = 1'b0;
        det_amp        = 1'b0;
        valid_out      = 1'b0;
        case (b_state_r)
            B_IDLE: begin
                if (valid_in) begin
                    b_state_s = B_COLLECT;
                    b_cnt_s   = '0;
                end else begin
                    b_state_s = B_IDLE;
                end
            end
            B_COLLECT: begin
                if (canon_valid) begin
                    if (b_cnt_r == CNT_LAST) begin
                        b_state_s     = B_WAIT;
                        b_cnt_s       = '0;
                        valid_p_set_s = 1'b1;
                    end else begin
                        b_cnt_s = b_cnt_r + CNT_ONE;
                    end
                end else begin
                    b_cnt_s = b_cnt_r;
                end
            end
            B_WAIT: begin
                if (alpha_done) begin
                    b_state_s = B_REDUCE;
                    lf_s      = '0;
                    dn_s      = '0;
                end else begin
                    b_state_s = B_WAIT;
                end
            end
            B_REDUCE: begin
                if (lf_r == CNT_LAST) begin
                    det_amp   = 1'b1;
                    b_state_s = B_SYNC;
                end else if (lit_bl) begin
                    ld_prodq      = 1'b1;
                    rot_down_beta = 1'b1;
                    dn_s          = (dn_r == CNT_LAST) ? dn_r : dn_r + CNT_ONE;
                end else begin
                    rot_left_beta  = 1'b1;
                    rot_left_qflag = 1'b1;
                    lf_s           = lf_r + CNT_ONE;
                end
            end
            B_SYNC: begin
                rot_left_beta  = 1'b1;
                rot_left_qflag = 1'b1;
                b_state_s      = B_REORDER;
            end
            B_REORDER: begin
                rot_down_beta = 1'b1;
                if (dn_r == CNT_LAST) begin
                    b_state_s = B_SHIFT;
                    b_cnt_s   = '0;
                end else begin
                    dn_s = dn_r + CNT_ONE;
                end
            end
            B_SHIFT: begin
                valid_out = 1'b1;
                if (b_cnt_r == CNT_LAST) begin
                    b_state_s     = B_IDLE;
                    b_cnt_s       = '0;
                    nonstab_set_s = next_nonstab;
                end else begin
                    b_cnt_s = b_cnt_r + CNT_ONE;
                end
            end
            default: b_state_s = B_IDLE;
        endcase
    end

    // State, counters and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state_r         <= A_IDLE;
            b_state_r         <= B_IDLE;
            a_cnt_r           <= '0;
            b_cnt_r           <= '0;
            lf_r              <= '0;
            dn_r              <= '0;
            idx_r             <= '0;
            gate_r            <= 3'd0;
            rot_basis_r       <= 1'b0;
            amp2_start_r      <= 1'b0;
            valid_p_r         <= 1'b0;
            valid_p_nonstab_r <= 1'b0;
        end else begin
            a_state_r         <= a_state_s;
            b_state_r         <= b_state_s;
            a_cnt_r           <= a_cnt_s;
            b_cnt_r           <= b_cnt_s;
            lf_r              <= lf_s;
            dn_r              <= dn_s;
            idx_r             <= idx_s;
            gate_r            <= gate_ld_s ? norm_gate(gate_type) : gate_r;
            rot_basis_r       <= rotate_s;
            amp2_start_r      <= amp2_set_s;
            valid_p_r         <= valid_p_set_s;
            valid_p_nonstab_r <= nonstab_set_s;
        end
    end

endmodule

// File: tb/tb_stabilizer_seq_ctrl.sv
// Directed bench for stabilizer_seq_ctrl (NUM_QUBIT=4, RD_LAT=2, WR_LAT=5).
module tb_stabilizer_seq_ctrl;
    import stab_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [2:0] gate_type = 3'd0;
    logic       next_nonstab = 1'b0;
    logic [4:0] valid_vec_cnt = 5'd16;
    logic       ram_busy = 1'b0;
    logic       amp2_done = 1'b0;
    logic       canon_valid = 1'b0;
    logic       lit_bl = 1'b0;
    logic       amp2_start, rd_ram_en, rd_amp_en, wr_amp_en;
    logic [3:0] rd_ram_addr, rd_amp_addr, wr_amp_addr;
    logic       rot_basis, rot_basis2, rot_q2, mask_op, alpha_done, valid_p;
    logic       rot_left_beta, rot_down_beta, ld_prodq, rot_left_qflag;
    logic       det_amp, valid_out, valid_p_nonstab;
    logic [28:0] all_outs;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int rd_cyc[16];
    int rda_cyc[16];
    int wra_cyc[16];
    int rd_n = 0, rda_n = 0, wra_n = 0, amp2_n = 0, ad_rise = -1;
    logic ad_prev = 1'b0;

    stabilizer_seq_ctrl #(.NUM_QUBIT(4), .RD_LAT(2), .WR_LAT(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .gate_type(gate_type),
        .next_nonstab(next_nonstab), .valid_vec_cnt(valid_vec_cnt), .ram_busy(ram_busy),
        .amp2_start(amp2_start), .amp2_done(amp2_done),
        .rd_ram_en(rd_ram_en), .rd_ram_addr(rd_ram_addr),
        .rd_amp_en(rd_amp_en), .rd_amp_addr(rd_amp_addr),
        .wr_amp_en(wr_amp_en), .wr_amp_addr(wr_amp_addr),
        .rot_basis(rot_basis), .rot_basis2(rot_basis2), .rot_q2(rot_q2),
        .mask_op(mask_op), .alpha_done(alpha_done),
        .canon_valid(canon_valid), .lit_bl(lit_bl), .valid_p(valid_p),
        .rot_left_beta(rot_left_beta), .rot_down_beta(rot_down_beta),
        .ld_prodq(ld_prodq), .rot_left_qflag(rot_left_qflag),
        .det_amp(det_amp), .valid_out(valid_out), .valid_p_nonstab(valid_p_nonstab)
    );

    assign all_outs = {amp2_start, rd_ram_en, rd_ram_addr, rd_amp_en, rd_amp_addr,
                       wr_amp_en, wr_amp_addr, rot_basis, rot_basis2, rot_q2, mask_op,
                       alpha_done, valid_p, rot_left_beta, rot_down_beta, ld_prodq,
                       rot_left_qflag, det_amp, valid_out, valid_p_nonstab};

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Event log sampled mid-cycle: cycle stamp per address and pulse counts.
    always @(negedge clk) begin
        if (rd_ram_en) begin rd_cyc[rd_ram_addr] = cyc_n; rd_n++; end
        if (rd_amp_en) begin rda_cyc[rd_amp_addr] = cyc_n; rda_n++; end
        if (wr_amp_en) begin wra_cyc[wr_amp_addr] = cyc_n; wra_n++; end
        if (amp2_start) amp2_n++;
        if (alpha_done && !ad_prev) ad_rise = cyc_n;
        ad_prev = alpha_done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid_in = 1'b0; ram_busy = 1'b0; amp2_done = 1'b0;
        canon_valid = 1'b0; lit_bl = 1'b0; next_nonstab = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        #1;
        checks++;
        if (all_outs !== 29'd0) begin
            failures++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        rst_n = 1'b1;
        repeat (3) cyc();
        checks++;
        if (all_outs !== 29'd0) begin
            failures++; $display("FAIL idle_outputs: got %h expected 0", all_outs);
        end
    endtask

    task automatic test_h_gate();
        int a0, r0, d0, w0, p;
        do_reset();
        valid_vec_cnt = 5'd16; gate_type = GT_H;
        a0 = amp2_n; r0 = rd_n; d0 = rda_n; w0 = wra_n;
        valid_in = 1'b1; repeat (4) cyc(); valid_in = 1'b0;
        repeat (4) cyc();
        checks++;
        if (amp2_n - a0 !== 1) begin failures++; $display("FAIL h_amp2_pulses: got %0d expected 1", amp2_n - a0); end
        checks++;
        if (rd_n - r0 !== 0) begin failures++; $display("FAIL h_rd_before_amp2: got %0d expected 0", rd_n - r0); end
        amp2_done = 1'b1; p = cyc_n; cyc(); amp2_done = 1'b0;
        repeat (30) cyc();
        checks++;
        if (rd_n - r0 !== 16) begin failures++; $display("FAIL h_rd_count: got %0d expected 16", rd_n - r0); end
        checks++;
        if (rda_n - d0 !== 16) begin failures++; $display("FAIL h_rda_count: got %0d expected 16", rda_n - d0); end
        checks++;
        if (wra_n - w0 !== 16) begin failures++; $display("FAIL h_wra_count: got %0d expected 16", wra_n - w0); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rd_cyc[i] !== p + 1 + i) begin failures++; $display("FAIL h_rd_cycle[%0d]: got %0d expected %0d", i, rd_cyc[i], p + 1 + i); end
            checks++;
            if (rda_cyc[i] !== p + 3 + i) begin failures++; $display("FAIL h_rda_cycle[%0d]: got %0d expected %0d", i, rda_cyc[i], p + 3 + i); end
            checks++;
            if (wra_cyc[i] !== p + 6 + i) begin failures++; $display("FAIL h_wra_cycle[%0d]: got %0d expected %0d", i, wra_cyc[i], p + 6 + i); end
        end
        checks++;
        if (ad_rise !== p + 23) begin failures++; $display("FAIL h_alpha_done_cycle: got %0d expected %0d", ad_rise, p + 23); end
    endtask

    task automatic test_cnot_stall();
        int k, s0, c;
        logic busy, rot_now, rot_prev, exp_rd;
        do_reset();
        valid_vec_cnt = 5'd5; gate_type = GT_CNOT;
        k = cyc_n;
        valid_in = 1'b1; repeat (4) cyc(); valid_in = 1'b0;
        s0 = k + 5;
        rot_prev = 1'b0;
        for (int n = 0; n < 23; n++) begin
            c = cyc_n;
            busy = (c >= s0 + 7) && (c <= s0 + 9);
            ram_busy = busy;
            #1;
            rot_now = (c >= s0) && (c <= s0 + 18) && !busy;
            exp_rd  = (c >= s0) && (c <= s0 + 4);
            checks++;
            if (rd_ram_en !== exp_rd) begin failures++; $display("FAIL cnot_rd_en@%0d: got %b expected %b", c - s0, rd_ram_en, exp_rd); end
            if (exp_rd) begin
                checks++;
                if (rd_ram_addr !== 4'(c - s0)) begin failures++; $display("FAIL cnot_rd_addr@%0d: got %0d expected %0d", c - s0, rd_ram_addr, c - s0); end
            end
            checks++;
            if (rot_basis2 !== (rot_now | rot_prev)) begin failures++; $display("FAIL cnot_rot_basis2@%0d: got %b expected %b", c - s0, rot_basis2, rot_now | rot_prev); end
            checks++;
            if (alpha_done !== (c >= s0 + 20)) begin failures++; $display("FAIL cnot_alpha_done@%0d: got %b expected %b", c - s0, alpha_done, c >= s0 + 20); end
            rot_prev = rot_now;
            cyc();
        end
        ram_busy = 1'b0;
    endtask

    task automatic test_pauli();
        logic [2:0] codes [2];
        int k, c;
        codes[0] = GT_PAULI; codes[1] = 3'd6;
        for (int g = 0; g < 2; g++) begin
            do_reset();
            valid_vec_cnt = 5'd16; gate_type = codes[g];
            k = cyc_n;
            valid_in = 1'b1; repeat (4) cyc(); valid_in = 1'b0;
            for (int n = 0; n < 6; n++) begin
                c = cyc_n;
                #1;
                checks++;
                if ({rd_ram_en, mask_op, alpha_done} !== {1'b0, c >= k + 5, c >= k + 6})
                    begin failures++; $display("FAIL pauli_g%0d@%0d: got rd/mask/done=%b%b%b expected 0%b%b", codes[g], c - k, rd_ram_en, mask_op, alpha_done, c >= k + 5, c >= k + 6); end
                cyc();
            end
        end
    endtask

    task automatic test_beta();
        logic [9:0] got, exp;
        for (int nn = 0; nn < 2; nn++) begin
            do_reset();
            gate_type = GT_PAULI; next_nonstab = (nn == 1);
            for (int t = 0; t < 22; t++) begin
                valid_in    = (t <= 3);
                canon_valid = (t >= 1) && (t <= 4);
                lit_bl      = (t == 7) || (t == 9);
                #1;
                got = {valid_p, alpha_done, ld_prodq, rot_down_beta, rot_left_beta,
                       rot_left_qflag, det_amp, valid_out, valid_p_nonstab, mask_op};
                exp = {t == 5, (t >= 6) && (t <= 16), (t == 7) || (t == 9),
                       (t == 7) || (t == 9) || (t == 14) || (t == 15),
                       (t == 8) || (t == 10) || (t == 11) || (t == 13),
                       (t == 8) || (t == 10) || (t == 11) || (t == 13),
                       t == 12, (t >= 16) && (t <= 19), (nn == 1) && (t == 20),
                       (t >= 5) && (t <= 16)};
                checks++;
                if (got !== exp) begin failures++; $display("FAIL beta_nn%0d@t%0d: got %b expected %b", nn, t, got, exp); end
                cyc();
            end
            valid_in = 1'b0; canon_valid = 1'b0; lit_bl = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] got, exp;
        logic exp_rd;
        do_reset();
        valid_vec_cnt = 5'd2; next_nonstab = 1'b0;
        for (int t = 0; t < 42; t++) begin
            valid_in    = (t <= 3) || ((t >= 32) && (t <= 35));
            gate_type   = (t <= 3) ? GT_S : GT_H;
            canon_valid = (t >= 1) && (t <= 4);
            lit_bl      = 1'b0;
            amp2_done   = (t == 38);
            #1;
            exp_rd = (t == 5) || (t == 6) || (t == 39) || (t == 40);
            got = {rd_ram_en, alpha_done, valid_out, amp2_start, mask_op, det_amp};
            exp = {exp_rd, (t >= 22) && (t <= 32), (t >= 32) && (t <= 35), t == 37,
                   ((t >= 5) && (t <= 32)) || (t >= 39), t == 26};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL b2b@t%0d: got %b expected %b", t, got, exp); end
            if (exp_rd) begin
                checks++;
                if (rd_ram_addr !== 4'((t < 20) ? t - 5 : t - 39)) begin failures++; $display("FAIL b2b_addr@t%0d: got %0d", t, rd_ram_addr); end
            end
            cyc();
        end
        valid_in = 1'b0; canon_valid = 1'b0; amp2_done = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int k, c;
        do_reset();
        valid_vec_cnt = 5'd16; gate_type = GT_CNOT;
        valid_in = 1'b1; repeat (4) cyc(); valid_in = 1'b0;
        repeat (8) cyc();
        #1;
        checks++;
        if ({rd_ram_en, wr_amp_en, mask_op} !== 3'b111) begin failures++; $display("FAIL midscan_active: got %b expected 111", {rd_ram_en, wr_amp_en, mask_op}); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== 29'd0) begin failures++; $display("FAIL midscan_reset_outputs: got %h expected 0", all_outs); end
        cyc();
        rst_n = 1'b1;
        gate_type = GT_PAULI;
        k = cyc_n;
        valid_in = 1'b1; repeat (4) cyc(); valid_in = 1'b0;
        for (int n = 0; n < 6; n++) begin
            c = cyc_n;
            #1;
            checks++;
            if ({wr_amp_en, rd_amp_en, alpha_done} !== {2'b00, c >= k + 6})
                begin failures++; $display("FAIL post_reset@%0d: got wr/rd/done=%b%b%b expected 00%b", c - k, wr_amp_en, rd_amp_en, alpha_done, c >= k + 6); end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_h_gate();
        test_cnot_stall();
        test_pauli();
        test_beta();
        test_back_to_back();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
